// File: rtl/trace_renderer_if.sv
// VGA pixel-stream bundle: raster position, sync/blank flags and 12-bit rgb.
// The renderer takes one of these on its input side and drives another on its output side.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/trace_renderer.sv
// Oscilloscope overlay: window border, grid and CHANNELS traces read from a sample RAM, 3-clk latency.
// Define TRACE_FILL_EN for continuous traces (vertical fill between columns); default build draws dots.

module trace_lane #(
    parameter int SAMPLE_W = 12,
    parameter int WIN_Y    = 100,
    parameter int WIN_H    = 256
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic [3:0]          i_shift,
    input  logic signed [10:0]  i_yoff,
    input  logic                i_col_ok,
    input  logic                i_hblnk,
    input  logic [10:0]         i_vcount,
    input  logic                i_en,
    output logic                o_hit
);
    localparam logic signed [SAMPLE_W:0] MID   = (SAMPLE_W+1)'(2**(SAMPLE_W-1));
    localparam logic signed [12:0]       Y_MID = 13'(WIN_Y + WIN_H/2);

    logic signed [SAMPLE_W:0] w_diff, w_d;
    logic signed [12:0]       w_y, w_v;
    logic signed [12:0]       r_y;
    logic                     w_on;

    // S1: offset-binary sample to screen row; larger sample sits higher on screen
    assign w_diff = $signed({1'b0, i_sample}) - MID;
    assign w_d    = w_diff >>> i_shift;
    assign w_y    = Y_MID - 13'(w_d) - 13'(i_yoff);
    assign w_v    = $signed({2'b00, i_vcount});

    always_ff @(posedge clk) begin
        if (rst) r_y <= '0;
        else     r_y <= w_y;
    end

`ifdef TRACE_FILL_EN
    logic signed [12:0] r_yp, w_lo, w_hi;
    logic               r_pok;

    // Previous column's row is kept even when it was off-window or disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_yp  <= '0;
            r_pok <= 1'b0;
        end else begin
            r_yp  <= r_y;
            r_pok <= i_col_ok && !i_hblnk;
        end
    end

    assign w_lo = (r_y < r_yp) ? r_y : r_yp;
    assign w_hi = (r_y < r_yp) ? r_yp : r_y;
    assign w_on = r_pok ? (w_v >= w_lo && w_v <= w_hi) : (w_v == r_y);
`else
    logic w_unused;
    assign w_unused = i_hblnk;
    assign w_on     = (w_v == r_y);
`endif

    assign o_hit = i_en && i_col_ok && w_on;
endmodule

module trace_renderer #(
    parameter int          CHANNELS = 2,
    parameter int          SAMPLE_W = 12,
    parameter int          DEPTH    = 256,
    parameter int          WIN_X    = 64,
    parameter int          WIN_Y    = 100,
    parameter int          WIN_W    = 256,
    parameter int          WIN_H    = 256,
    parameter int          GRID     = 32,
    parameter logic [47:0] CH_COLOR = {12'h0F0, 12'hF0F, 12'h0FF, 12'hAA0},
    localparam int         AW       = $clog2(DEPTH)
)(
    input  logic                         clk,
    input  logic                         rst,
    vga_if.in                            in,
    vga_if.out                           out,
    output logic [AW-1:0]                rd_addr,
    input  logic [CHANNELS*SAMPLE_W-1:0] rd_data,
    input  logic signed [10:0]           x_off,
    input  logic signed [10:0]           y_off,
    input  logic [3:0]                   scale_shift,
    input  logic [CHANNELS-1:0]          ch_en
);
    localparam logic [10:0] X0     = 11'(WIN_X);
    localparam logic [10:0] X1     = 11'(WIN_X + WIN_W - 1);
    localparam logic [10:0] Y0     = 11'(WIN_Y);
    localparam logic [10:0] Y1     = 11'(WIN_Y + WIN_H - 1);
    localparam logic [10:0] GMASK  = 11'(GRID - 1);
    localparam logic [4:0]  SH_MAX = 5'(SAMPLE_W - 1);

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } tim_t;

    tim_t                  w_t0, r_t1, r_t2;
    logic                  r_ok1, r_ok2;
    logic                  r_vb_d;
    logic signed [10:0]    r_xoff, r_yoff;
    logic [3:0]            r_shift;
    logic [CHANNELS-1:0]   r_en;
    logic signed [12:0]    w_idx;
    logic                  w_col_ok;
    logic [CHANNELS-1:0]   w_hit;
    logic                  w_incol, w_inrow, w_border, w_grid;
    logic [10:0]           w_hoff, w_voff;
    logic [11:0]           w_rgb;

    // View settings only move on the vblank rising edge so a frame never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vb_d  <= 1'b0;
            r_xoff  <= '0;
            r_yoff  <= '0;
            r_shift <= '0;
            r_en    <= '0;
        end else begin
            r_vb_d <= in.vblnk;
            if (in.vblnk && !r_vb_d) begin
                r_xoff  <= x_off;
                r_yoff  <= y_off;
                r_shift <= ({1'b0, scale_shift} > SH_MAX) ? SH_MAX[3:0] : scale_shift;
                r_en    <= ch_en;
            end
        end
    end

    // S0: sample index for this column; out-of-range columns are masked, never wrapped
    assign w_t0     = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};
    assign w_idx    = $signed({2'b00, in.hcount}) - 13'(WIN_X) + 13'(r_xoff);
    assign w_col_ok = (in.hcount >= X0) && (in.hcount <= X1) && !w_idx[12]
                      && (w_idx < $signed(13'(DEPTH)));
    assign rd_addr  = rst ? '0 : w_idx[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_t1  <= '0;
            r_t2  <= '0;
            r_ok1 <= 1'b0;
            r_ok2 <= 1'b0;
        end else begin
            r_t1  <= w_t0;
            r_t2  <= r_t1;
            r_ok1 <= w_col_ok;
            r_ok2 <= r_ok1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        trace_lane #(.SAMPLE_W(SAMPLE_W), .WIN_Y(WIN_Y), .WIN_H(WIN_H)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_sample (rd_data[c*SAMPLE_W +: SAMPLE_W]),
            .i_shift  (r_shift),
            .i_yoff   (r_yoff),
            .i_col_ok (r_ok2),
            .i_hblnk  (r_t2.hb),
            .i_vcount (r_t2.v),
            .i_en     (r_en[c]),
            .o_hit    (w_hit[c])
        );
    end

    // S2: compose overlay
    assign w_incol  = (r_t2.h >= X0) && (r_t2.h <= X1);
    assign w_inrow  = (r_t2.v >= Y0) && (r_t2.v <= Y1);
    assign w_hoff   = r_t2.h - X0;
    assign w_voff   = r_t2.v - Y0;
    assign w_border = w_incol && w_inrow &&
                      (r_t2.h == X0 || r_t2.h == X1 || r_t2.v == Y0 || r_t2.v == Y1);
    assign w_grid   = w_incol && w_inrow &&
                      ((w_hoff & GMASK) == 11'd0 || (w_voff & GMASK) == 11'd0);

    always_comb begin
        w_rgb = r_t2.rgb;
        if (!r_t2.hb && !r_t2.vb) begin
            if (w_grid)   w_rgb = 12'h444;
            if (w_border) w_rgb = 12'hFFF;
            // Walk down so channel 0 is applied last and wins
            for (int c = CHANNELS - 1; c >= 0; c--)
                if (w_hit[c] && w_inrow) w_rgb = CH_COLOR[c*12 +: 12];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= r_t2.h;
            out.vcount <= r_t2.v;
            out.hsync  <= r_t2.hs;
            out.vsync  <= r_t2.vs;
            out.hblnk  <= r_t2.hb;
            out.vblnk  <= r_t2.vb;
            out.rgb    <= w_rgb;
        end
    end
endmodule

// File: tb/tb_trace_renderer.sv
// Directed bench for trace_renderer: drives short raster lines, captures the delayed output row
// and checks hand-computed colours at chosen columns.
module tb_trace_renderer;
    localparam logic [11:0] BG  = 12'h123;
    localparam logic [11:0] C0  = 12'hAA0;
    localparam logic [11:0] C1  = 12'h0FF;
    localparam logic [11:0] GR  = 12'h444;
    localparam logic [11:0] BD  = 12'hFFF;
`ifdef TRACE_FILL_EN
    localparam logic [11:0] EXP_FILL = 12'hAA0;
`else
    localparam logic [11:0] EXP_FILL = 12'h444;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         rd_addr;
    logic [23:0]        rd_data;
    logic signed [10:0] x_off, y_off;
    logic [3:0]         scale_shift;
    logic [1:0]         ch_en;
    logic [11:0]        mem0 [256];
    logic [11:0]        mem1 [256];
    logic [11:0]        cap  [2048];
    int                 n_cmp = 0;
    int                 n_bad = 0;

    vga_if vin ();
    vga_if vout ();

    always #5 clk = ~clk;

    always_ff @(posedge clk) rd_data <= {mem1[rd_addr], mem0[rd_addr]};

    trace_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .in          (vin),
        .out         (vout),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .x_off       (x_off),
        .y_off       (y_off),
        .scale_shift (scale_shift),
        .ch_en       (ch_en)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set(input int h, input int v, input logic hb, input logic vb, input logic [11:0] rgb);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hsync  = hb;
        vin.vsync  = vb;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb;
    endtask

    task automatic drv(input int h, input int v, input logic hb, input logic vb, input logic [11:0] rgb);
        @(negedge clk);
        set(h, v, hb, vb, rgb);
    endtask

    task automatic vbl();
        drv(0, 0, 1'b1, 1'b0, 12'h0);
        drv(0, 0, 1'b1, 1'b1, 12'h0);
        drv(0, 0, 1'b1, 1'b0, 12'h0);
    endtask

    // One visible row from col 56 to 330, then blank pixels to flush the 3-clk pipe
    task automatic line(input int v);
        for (int i = 0; i < 2048; i++) cap[i] = 'x;
        for (int h = 56; h <= 333; h++) begin
            @(negedge clk);
            if (!vout.hblnk && !vout.vblnk && vout.vcount == 11'(v)) cap[vout.hcount] = vout.rgb;
            if (h <= 330) set(h, v, 1'b0, 1'b0, BG);
            else          set(0, v, 1'b1, 1'b0, 12'h0);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem0[k] = 12'd2048;
            mem1[k] = 12'd2048;
        end
        x_off = '0; y_off = '0; scale_shift = '0; ch_en = 2'b11;
        rst = 1'b1;
        set(5, 228, 1'b0, 1'b0, BG);
        repeat (2) @(negedge clk);
        chk("reset_rgb", 16'(vout.rgb), 16'h0);
        chk("reset_hcount", 16'(vout.hcount), 16'h0);
        chk("reset_rd_addr", 16'(rd_addr), 16'h0);
        rst = 1'b0;

        // 1: flat midscale ch0 -> row 228
        ch_en = 2'b01;
        vbl();
        line(228);
        chk("t1_col64", 16'(cap[64]), 16'(C0));
        chk("t1_col200", 16'(cap[200]), 16'(C0));
        chk("t1_col319", 16'(cap[319]), 16'(C0));
        chk("t1_col63_out", 16'(cap[63]), 16'(BG));
        chk("t1_col320_out", 16'(cap[320]), 16'(BG));
        line(229);
        chk("t1_grid_col96", 16'(cap[96]), 16'(GR));
        chk("t1_plain_col100", 16'(cap[100]), 16'(BG));
        line(100);
        chk("t1_border_row100", 16'(cap[150]), 16'(BD));
        drv(0, 5, 1'b1, 1'b0, 12'h0);
        drv(0, 5, 1'b1, 1'b0, 12'h0);
        drv(0, 5, 1'b1, 1'b0, 12'h0);
        drv(777, 5, 1'b1, 1'b0, 12'h0);
        drv(0, 5, 1'b1, 1'b0, 12'h0);
        drv(0, 5, 1'b1, 1'b0, 12'h0);
        chk("lat_2clk", 16'(vout.hcount), 16'd0);
        drv(0, 5, 1'b1, 1'b0, 12'h0);
        chk("lat_3clk", 16'(vout.hcount), 16'd777);
        drv(70, 228, 1'b0, 1'b0, BG);
        #1 chk("rd_addr_col70", 16'(rd_addr), 16'd6);

        // 2: step from +64 to -64 at idx 128 -> rows 164 / 292, joined at col 192
        for (int k = 0; k < 256; k++) mem0[k] = (k < 128) ? 12'd2112 : 12'd1984;
        line(200);
        chk("t2_col192_mid", 16'(cap[192]), 16'(EXP_FILL));
        line(164);
        chk("t2_row164_col191", 16'(cap[191]), 16'(C0));
        chk("t2_row164_col150", 16'(cap[150]), 16'(C0));
        line(292);
        chk("t2_row292_col192", 16'(cap[192]), 16'(C0));
        chk("t2_row292_col250", 16'(cap[250]), 16'(C0));
        line(165);
        chk("t2_row165_col150", 16'(cap[150]), 16'(BG));
        chk("t2_row165_col193", 16'(cap[193]), 16'(BG));

        // 3: shift=2, then x_off=10 only after the next vblank rise
        mem0[250] = 12'd1983;
        scale_shift = 4'd2;
        vbl();
        x_off = 11'sd10;
        line(212);
        chk("t3_row212_col150", 16'(cap[150]), 16'(C0));
        line(244);
        chk("t3_row244_col192", 16'(cap[192]), 16'(C0));
        chk("t3_row244_col191", 16'(cap[191]), 16'(BG));
        vbl();
        line(244);
        chk("t3_xoff_col182", 16'(cap[182]), 16'(C0));
        chk("t3_xoff_col181", 16'(cap[181]), 16'(BG));
        line(245);
        chk("t3_floor_col304", 16'(cap[304]), 16'(C0));
        line(164);
        chk("t3_scaled_row164", 16'(cap[150]), 16'(GR));
        scale_shift = 4'd15;
        x_off = '0;
        vbl();
        line(229);
        chk("t3_clamp_col250", 16'(cap[250]), 16'(C0));
        chk("t3_clamp_col150", 16'(cap[150]), 16'(BG));

        // 4: negative pan leaves the first 20 columns trace-free
        for (int k = 0; k < 256; k++) mem0[k] = 12'd2048;
        mem0[0] = 12'd2112;
        scale_shift = 4'd0;
        x_off = -11'sd20;
        vbl();
        line(228);
        chk("t4_col64_border", 16'(cap[64]), 16'(BD));
        chk("t4_col83_grid", 16'(cap[83]), 16'(GR));
        chk("t4_col90_trace", 16'(cap[90]), 16'(C0));
        line(164);
        chk("t4_col84_point", 16'(cap[84]), 16'(C0));
        chk("t4_col83_free", 16'(cap[83]), 16'(GR));
        line(200);
        chk("t4_col84_nofill", 16'(cap[84]), 16'(BG));
        drv(100, 228, 1'b0, 1'b0, BG);
        #1 chk("t4_rd_addr", 16'(rd_addr), 16'd16);

        // 5: channel priority and blanking pass-through
        mem0[0] = 12'd2048;
        x_off = '0;
        ch_en = 2'b11;
        vbl();
        line(228);
        chk("t5_both_ch0", 16'(cap[100]), 16'(C0));
        ch_en = 2'b10;
        vbl();
        line(228);
        chk("t5_ch1_col100", 16'(cap[100]), 16'(C1));
        chk("t5_ch1_col64", 16'(cap[64]), 16'(C1));
        drv(150, 228, 1'b1, 1'b0, 12'h5A5);
        drv(0, 228, 1'b1, 1'b0, 12'h0);
        drv(0, 228, 1'b1, 1'b0, 12'h0);
        drv(0, 228, 1'b1, 1'b0, 12'h0);
        chk("t5_blank_rgb", 16'(vout.rgb), 16'h5A5);
        chk("t5_blank_hcount", 16'(vout.hcount), 16'd150);

        // 6: reset mid-line clears outputs and view until the next vblank rise
        ch_en = 2'b01;
        vbl();
        drv(100, 228, 1'b0, 1'b0, BG);
        drv(101, 228, 1'b0, 1'b0, BG);
        drv(102, 228, 1'b0, 1'b0, BG);
        drv(103, 228, 1'b0, 1'b0, BG);
        rst = 1'b1;
        drv(104, 228, 1'b0, 1'b0, BG);
        chk("t6_rst_rgb", 16'(vout.rgb), 16'h0);
        chk("t6_rst_hcount", 16'(vout.hcount), 16'h0);
        rst = 1'b0;
        line(228);
        chk("t6_no_trace_col100", 16'(cap[100]), 16'(GR));
        chk("t6_no_trace_col150", 16'(cap[150]), 16'(GR));
        vbl();
        line(228);
        chk("t6_trace_back", 16'(cap[100]), 16'(C0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
